// File: rtl/serial_pkg.sv
// Shared definitions for the serial feeder / sequence-detector path:
// serializer FSM states, frame-length helper and the default idle level.
package serial_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    // Level held on the serial line between frames; the detector bench uses it too.
    localparam logic SER_IDLE_LEVEL = 1'b0;

    // Bits per frame: data bits plus an optional trailing parity bit.
    function automatic int ser_frame_len(input int width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial feeder: accepts a word on a valid/ready handshake and
// shifts it out MSB-first, one bit per clk. A new word can be accepted on the
// final bit of the current frame, so consecutive frames run without a gap.
// Optional macro WORD_SERIALIZER_PARITY_EN appends an even-parity bit per frame.
module word_serializer
    import serial_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = SER_IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int N = ser_frame_len(WIDTH, 1'b1);
`else
    localparam int N = ser_frame_len(WIDTH, 1'b0);
`endif
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    ser_state_t       r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    // Bits still to be sent, MSB-aligned; the bit on dout has already left it.
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic             r_dout, w_dout_nxt;
    logic             r_dout_valid, w_dout_valid_nxt;
    logic             r_busy, w_busy_nxt;
    logic             w_last;
    logic             w_accept;
`ifdef WORD_SERIALIZER_PARITY_EN
    logic             r_par, w_par_nxt;
`endif

    assign w_last   = (r_state == SER_SHIFT) && (r_cnt == LAST);
    assign w_accept = load_valid && load_ready;

    // Ready in IDLE or on the frame's final bit; never during reset.
    always_comb begin
        load_ready = !reset && ((r_state == SER_IDLE) || w_last);
    end

    // Next-state: load on accept, otherwise advance the frame or fall idle.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_shift_nxt      = r_shift;
        w_dout_nxt       = r_dout;
        w_dout_valid_nxt = r_dout_valid;
        w_busy_nxt       = r_busy;
`ifdef WORD_SERIALIZER_PARITY_EN
        w_par_nxt        = r_par;
`endif
        if (w_accept) begin
            // MSB goes straight to dout so it shows the cycle after the accept.
            w_state_nxt      = SER_SHIFT;
            w_cnt_nxt        = '0;
            w_dout_nxt       = load_data[WIDTH-1];
            w_shift_nxt      = {load_data[WIDTH-2:0], 1'b0};
            w_dout_valid_nxt = 1'b1;
            w_busy_nxt       = 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
            w_par_nxt        = ^load_data;
`endif
        end else begin
            case (r_state)
                SER_SHIFT: begin
                    if (w_last) begin
                        w_state_nxt      = SER_IDLE;
                        w_cnt_nxt        = '0;
                        w_dout_nxt       = IDLE_LEVEL;
                        w_dout_valid_nxt = 1'b0;
                        w_busy_nxt       = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
`ifdef WORD_SERIALIZER_PARITY_EN
                        if (r_cnt == CW'(WIDTH - 1)) begin
                            w_dout_nxt = r_par;
                        end else begin
                            w_dout_nxt  = r_shift[WIDTH-1];
                            w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
                        end
`else
                        w_dout_nxt  = r_shift[WIDTH-1];
                        w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
`endif
                    end
                end
                default: begin
                    w_state_nxt      = SER_IDLE;
                    w_cnt_nxt        = '0;
                    w_dout_nxt       = IDLE_LEVEL;
                    w_dout_valid_nxt = 1'b0;
                    w_busy_nxt       = 1'b0;
                end
            endcase
        end
    end

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= SER_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_dout       <= IDLE_LEVEL;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_busy       <= w_busy_nxt;
`ifdef WORD_SERIALIZER_PARITY_EN
            r_par        <= w_par_nxt;
`endif
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_word_serializer.sv
// Directed table-driven bench for word_serializer. Each row is one clock
// cycle: inputs driven after the falling edge, outputs checked 1ns later.
// Parity rows are included when WORD_SERIALIZER_PARITY_EN is defined.
module tb_word_serializer;

`ifdef WORD_SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       lv;
        logic [7:0] ld;
        logic [3:0] exp;   // {dout, dout_valid, busy, load_ready}
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, reset1;
    logic [7:0] load_data, load_data1;
    logic       load_valid, load_valid1;
    logic       load_ready, dout, dout_valid, busy;
    logic       load_ready1, dout1, dout_valid1, busy1;

    int n_pass = 0;
    int n_total = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    word_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) u_dut (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .dout(dout), .dout_valid(dout_valid), .busy(busy)
    );

    word_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b1)) u_dut1 (
        .clk(clk), .reset(reset1), .load_data(load_data1), .load_valid(load_valid1),
        .load_ready(load_ready1), .dout(dout1), .dout_valid(dout_valid1), .busy(busy1)
    );

    function automatic void p(input logic rst, input logic lv, input logic [7:0] ld,
                              input logic d, input logic dv, input logic b, input logic r);
        vec_t v;
        v.rst = rst; v.lv = lv; v.ld = ld; v.exp = {d, dv, b, r};
        tbl.push_back(v);
    endfunction

    initial begin
        logic [3:0] got;
        reset = 1'b1; load_valid = 1'b0; load_data = 8'h00;
        reset1 = 1'b1; load_valid1 = 1'b0; load_data1 = 8'h00;

        // reset state
        p(1, 0, 8'h00, 0, 0, 0, 0);
        // A5 single word
        p(0, 1, 8'hA5, 0, 0, 0, 1);
        p(0, 0, 8'h00, 1, 1, 1, 0);
        p(0, 0, 8'h00, 0, 1, 1, 0);
        p(0, 0, 8'h00, 1, 1, 1, 0);
        p(0, 0, 8'h00, 0, 1, 1, 0);
        p(0, 0, 8'h00, 0, 1, 1, 0);
        p(0, 0, 8'h00, 1, 1, 1, 0);
        p(0, 0, 8'h00, 0, 1, 1, 0);
        p(0, 0, 8'h00, 1, 1, 1, !PAR);
        if (PAR) p(0, 0, 8'h00, 0, 1, 1, 1);
        p(0, 0, 8'h00, 0, 0, 0, 1);
        // AA then 0A back-to-back, load_valid held
        p(0, 1, 8'hAA, 0, 0, 0, 1);
        p(0, 1, 8'hAA, 1, 1, 1, 0);
        p(0, 1, 8'hAA, 0, 1, 1, 0);
        p(0, 1, 8'hAA, 1, 1, 1, 0);
        p(0, 1, 8'hAA, 0, 1, 1, 0);
        p(0, 1, 8'hAA, 1, 1, 1, 0);
        p(0, 1, 8'hAA, 0, 1, 1, 0);
        p(0, 1, 8'h0A, 1, 1, 1, 0);
        p(0, 1, 8'h0A, 0, 1, 1, !PAR);
        if (PAR) p(0, 1, 8'h0A, 0, 1, 1, 1);
        p(0, 0, 8'h00, 0, 1, 1, 0);
        p(0, 0, 8'h00, 0, 1, 1, 0);
        p(0, 0, 8'h00, 0, 1, 1, 0);
        p(0, 0, 8'h00, 0, 1, 1, 0);
        p(0, 0, 8'h00, 1, 1, 1, 0);
        p(0, 0, 8'h00, 0, 1, 1, 0);
        p(0, 0, 8'h00, 1, 1, 1, 0);
        p(0, 0, 8'h00, 0, 1, 1, !PAR);
        if (PAR) p(0, 0, 8'h00, 0, 1, 1, 1);
        p(0, 0, 8'h00, 0, 0, 0, 1);
        // 55 with an FF pulse mid-word (ignored), then FF re-presented
        p(0, 1, 8'h55, 0, 0, 0, 1);
        p(0, 0, 8'h00, 0, 1, 1, 0);
        p(0, 0, 8'h00, 1, 1, 1, 0);
        p(0, 1, 8'hFF, 0, 1, 1, 0);
        p(0, 0, 8'h00, 1, 1, 1, 0);
        p(0, 0, 8'h00, 0, 1, 1, 0);
        p(0, 0, 8'h00, 1, 1, 1, 0);
        p(0, 0, 8'h00, 0, 1, 1, 0);
        p(0, 0, 8'h00, 1, 1, 1, !PAR);
        if (PAR) p(0, 0, 8'h00, 0, 1, 1, 1);
        p(0, 1, 8'hFF, 0, 0, 0, 1);
        p(0, 0, 8'h00, 1, 1, 1, 0);
        p(1, 0, 8'h00, 1, 1, 1, 0);
        p(0, 0, 8'h00, 0, 0, 0, 1);
        // C3 aborted by reset on its 4th bit
        p(0, 1, 8'hC3, 0, 0, 0, 1);
        p(0, 0, 8'h00, 1, 1, 1, 0);
        p(0, 0, 8'h00, 1, 1, 1, 0);
        p(0, 0, 8'h00, 0, 1, 1, 0);
        p(1, 0, 8'h00, 0, 1, 1, 0);
        p(0, 0, 8'h00, 0, 0, 0, 1);
        p(0, 0, 8'h00, 0, 0, 0, 1);
        p(0, 0, 8'h00, 0, 0, 0, 1);
        p(0, 0, 8'h00, 0, 0, 0, 1);
        p(0, 0, 8'h00, 0, 0, 0, 1);
        // 07: parity bit 1 (parity builds only)
        if (PAR) begin
            p(0, 1, 8'h07, 0, 0, 0, 1);
            p(0, 0, 8'h00, 0, 1, 1, 0);
            p(0, 0, 8'h00, 0, 1, 1, 0);
            p(0, 0, 8'h00, 0, 1, 1, 0);
            p(0, 0, 8'h00, 0, 1, 1, 0);
            p(0, 0, 8'h00, 0, 1, 1, 0);
            p(0, 0, 8'h00, 1, 1, 1, 0);
            p(0, 0, 8'h00, 1, 1, 1, 0);
            p(0, 0, 8'h00, 1, 1, 1, 0);
            p(0, 0, 8'h00, 1, 1, 1, 1);
            p(0, 0, 8'h00, 0, 0, 0, 1);
        end

        repeat (2) @(posedge clk);

        // IDLE_LEVEL=1 instance idles high after reset
        @(negedge clk);
        reset1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            n_total++;
            if (dout1 === 1'b1 && dout_valid1 === 1'b0 && busy1 === 1'b0 && load_ready1 === 1'b1)
                n_pass++;
            else
                $display("FAIL idle_hi cyc%0d got dout/dv/busy/rdy=%b%b%b%b exp=1001",
                         k, dout1, dout_valid1, busy1, load_ready1);
        end

        // table replay on the IDLE_LEVEL=0 instance
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst;
            load_valid = tbl[i].lv;
            load_data = tbl[i].ld;
            #1;
            got = {dout, dout_valid, busy, load_ready};
            n_total++;
            if (got === tbl[i].exp)
                n_pass++;
            else
                $display("FAIL row%0d ld=%h got dout/dv/busy/rdy=%b exp=%b",
                         i, tbl[i].ld, got, tbl[i].exp);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
